// File: rtl/audio_seq_pkg.sv
// Shared definitions for the audio stream sequencer.
//   seq_state_t    : sequencer FSM state encoding
//   DATA_W_DEF     : default sample width (two's complement)
//   LOG2_TAPS_DEF  : default log2 of the moving-average length
package audio_seq_pkg;

    localparam int DATA_W_DEF    = 24;
    localparam int LOG2_TAPS_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        ACC_L,
        ACC_R,
        OUT_WAIT,
        WRITE
    } seq_state_t;

endpackage

// File: rtl/sample_history.sv
// Per-channel circular sample buffer of 2**LOG2_TAPS entries.
// Writes land at an internal write pointer that advances (mod TAPS) on every
// write, so the newest sample always replaces the oldest one. Reads are
// random-access by absolute index.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears all entries)
//   wr_en      : store wr_data at the write pointer and advance it
//   wr_data    : sample to store
//   rd_idx     : entry to read
//   rd_data    : combinational read data
module sample_history
    import audio_seq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LOG2_TAPS = LOG2_TAPS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [LOG2_TAPS-1:0] rd_idx,
    output logic [DATA_W-1:0]    rd_data
);

    localparam int TAPS = 2 ** LOG2_TAPS;

    logic [DATA_W-1:0]    mem [TAPS];
    logic [LOG2_TAPS-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            // pointer width is exactly LOG2_TAPS, so the add wraps mod TAPS
            wr_ptr      <= wr_ptr + LOG2_TAPS'(1);
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/audio_stream_sequencer.sv
// Stereo audio sequencer: pops a sample pair from the codec, runs a TAPS-point
// moving average per channel (or passes the raw pair through when bypass=1),
// and pushes the result back to the codec.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   read_ready, readdata_left/right : codec input sample available + data
//   read                            : one-cycle pop strobe
//   write_ready                     : codec can accept an output sample
//   writedata_left/right, write     : registered output pair + push strobe
//   bypass                          : 1 = raw pass-through, 0 = filter
//   busy                            : high whenever not IDLE
//   overrun                         : sticky write_ready stall flag
//   sample_count                    : completed writes, mod 2^16
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for read_ready
// CAPTURE  | read strobe, store pre-shifted samples, pick filter or bypass
// ACC_L    | TAPS cycles summing left history through the shared adder
// ACC_R    | TAPS cycles summing right history, then load both outputs
// OUT_WAIT | waiting for write_ready, counting stall cycles
// WRITE    | write strobe, bump sample_count
module audio_stream_sequencer
    import audio_seq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LOG2_TAPS = LOG2_TAPS_DEF,
    parameter int STALL_MAX = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    input  logic              write_ready,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              write,
    input  logic              bypass,
    output logic              busy,
    output logic              overrun,
    output logic [15:0]       sample_count
);

    localparam int TAPS    = 2 ** LOG2_TAPS;
    localparam int STALL_W = $clog2(STALL_MAX + 2);

    seq_state_t           state;
    logic [LOG2_TAPS-1:0] tap_cnt;
    logic [DATA_W-1:0]    acc;
    logic [DATA_W-1:0]    sum_l;
    logic [STALL_W-1:0]   stall_cnt;

    logic                 hist_we;
    logic [DATA_W-1:0]    shift_l;
    logic [DATA_W-1:0]    shift_r;
    logic [DATA_W-1:0]    hist_l;
    logic [DATA_W-1:0]    hist_r;
    logic [DATA_W-1:0]    addend;
    logic [DATA_W-1:0]    acc_next;

    // Pre-dividing each entry by TAPS keeps the TAPS-entry sum inside DATA_W.
    assign shift_l = $signed(readdata_left)  >>> LOG2_TAPS;
    assign shift_r = $signed(readdata_right) >>> LOG2_TAPS;
    assign hist_we = (state == CAPTURE);

    sample_history #(.DATA_W(DATA_W), .LOG2_TAPS(LOG2_TAPS)) u_hist_l (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (hist_we),
        .wr_data (shift_l),
        .rd_idx  (tap_cnt),
        .rd_data (hist_l)
    );

    sample_history #(.DATA_W(DATA_W), .LOG2_TAPS(LOG2_TAPS)) u_hist_r (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (hist_we),
        .wr_data (shift_r),
        .rd_idx  (tap_cnt),
        .rd_data (hist_r)
    );

    // Single adder shared by both channels; the operand follows the state.
    assign addend   = (state == ACC_R) ? hist_r : hist_l;
    assign acc_next = acc + addend;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            read            <= 1'b0;
            write           <= 1'b0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
            writedata_left  <= '0;
            writedata_right <= '0;
            sample_count    <= '0;
            tap_cnt         <= '0;
            acc             <= '0;
            sum_l           <= '0;
            stall_cnt       <= '0;
        end else begin
            read  <= 1'b0;
            write <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_ready) begin
                        read  <= 1'b1;
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    acc     <= '0;
                    tap_cnt <= LOG2_TAPS'(TAPS - 1);
                    // bypass is sampled only here; the branch taken is the latch
                    if (bypass) begin
                        writedata_left  <= readdata_left;
                        writedata_right <= readdata_right;
                        stall_cnt       <= '0;
                        state           <= OUT_WAIT;
                    end else begin
                        state <= ACC_L;
                    end
                end
                ACC_L: begin
                    if (tap_cnt == '0) begin
                        sum_l   <= acc_next;
                        acc     <= '0;
                        tap_cnt <= LOG2_TAPS'(TAPS - 1);
                        state   <= ACC_R;
                    end else begin
                        acc     <= acc_next;
                        tap_cnt <= tap_cnt - LOG2_TAPS'(1);
                    end
                end
                ACC_R: begin
                    if (tap_cnt == '0) begin
                        writedata_left  <= sum_l;
                        writedata_right <= acc_next;
                        acc             <= '0;
                        stall_cnt       <= '0;
                        state           <= OUT_WAIT;
                    end else begin
                        acc     <= acc_next;
                        tap_cnt <= tap_cnt - LOG2_TAPS'(1);
                    end
                end
                OUT_WAIT: begin
                    if (write_ready) begin
                        write <= 1'b1;
                        state <= WRITE;
                    end else begin
                        // saturate just past the limit so the counter never wraps
                        if (stall_cnt != STALL_W'(STALL_MAX + 1)) begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                        if (stall_cnt >= STALL_W'(STALL_MAX)) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    sample_count <= sample_count + 16'd1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Self-checking bench for audio_stream_sequencer: table-driven sample
// vectors plus hand-written sequences, with a write-side scoreboard.
module tb_audio_stream_sequencer;

    localparam int DATA_W    = 24;
    localparam int LOG2_TAPS = 3;
    localparam int STALL_MAX = 1024;

    logic              clk;
    logic              reset;
    logic              read_ready;
    logic [DATA_W-1:0] readdata_left;
    logic [DATA_W-1:0] readdata_right;
    logic              read;
    logic              write_ready;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;
    logic              write;
    logic              bypass;
    logic              busy;
    logic              overrun;
    logic [15:0]       sample_count;

    audio_stream_sequencer #(
        .DATA_W(DATA_W), .LOG2_TAPS(LOG2_TAPS), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read            (read),
        .write_ready     (write_ready),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .write           (write),
        .bypass          (bypass),
        .busy            (busy),
        .overrun         (overrun),
        .sample_count    (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
    } exp_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        byp;
        logic [23:0] el;
        logic [23:0] er;
        int          lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[11];
    int   total   = 0;
    int   bad     = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (write) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got write=1 L=%h R=%h expected no pending sample",
                         writedata_left, writedata_right);
            end else begin
                mon_e = sb.pop_front();
                if (writedata_left !== mon_e.l || writedata_right !== mon_e.r || read !== 1'b0) begin
                    bad++;
                    $display("FAIL writedata: got L=%h R=%h read=%b expected L=%h R=%h read=0",
                             writedata_left, writedata_right, read, mon_e.l, mon_e.r);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        read_ready  = 1'b0;
        write_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_cnt = 0;
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r, input logic byp,
                        input logic [23:0] el, input logic [23:0] er, input int lat);
        int   n;
        int   extra;
        exp_t e;
        @(negedge clk);
        readdata_left  = l;
        readdata_right = r;
        bypass         = byp;
        read_ready     = 1'b1;
        n = 0;
        while (!read && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("read_pulse", 32'(read), 32'd1);
        read_ready = 1'b0;
        e.l = el;
        e.r = er;
        sb.push_back(e);
        n = 0;
        extra = 0;
        while (!write && n < 200) begin
            @(negedge clk);
            n++;
            if (read) extra++;
            if (byp && n == 1) begin
                check("bypass_early_l", 32'(writedata_left), 32'(l));
                check("bypass_early_r", 32'(writedata_right), 32'(r));
            end
        end
        check("latency", n, lat);
        check("read_extra", extra, 0);
        @(negedge clk);
        exp_cnt++;
        check("sample_count", 32'(sample_count), exp_cnt);
    endtask

    initial begin
        int          n;
        int          reads;
        int          writes;
        logic [23:0] x;
        logic [23:0] ex;

        reset          = 1'b1;
        read_ready     = 1'b0;
        write_ready    = 1'b1;
        bypass         = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;

        vecs[0]  = '{24'h000800, 24'hFFF800, 1'b0, 24'h000100, 24'hFFFF00, 18};
        vecs[1]  = '{24'h000800, 24'hFFF800, 1'b0, 24'h000200, 24'hFFFE00, 18};
        vecs[2]  = '{24'h000800, 24'h000000, 1'b0, 24'h000300, 24'hFFFE00, 18};
        vecs[3]  = '{24'h000800, 24'h000080, 1'b0, 24'h000400, 24'hFFFE10, 18};
        vecs[4]  = '{24'h000800, 24'h000000, 1'b0, 24'h000500, 24'hFFFE10, 18};
        vecs[5]  = '{24'h000800, 24'h000000, 1'b0, 24'h000600, 24'hFFFE10, 18};
        vecs[6]  = '{24'h000800, 24'h000000, 1'b0, 24'h000700, 24'hFFFE10, 18};
        vecs[7]  = '{24'h000800, 24'h000000, 1'b0, 24'h000800, 24'hFFFE10, 18};
        vecs[8]  = '{24'h000000, 24'h000000, 1'b0, 24'h000700, 24'hFFFF10, 18};
        vecs[9]  = '{24'h123456, 24'hABCDEF, 1'b1, 24'h123456, 24'hABCDEF, 2};
        // bypassed samples still enter history (pre-shifted) at the write pointer
        vecs[10] = '{24'h000000, 24'h000000, 1'b0, 24'h024B8A, 24'hF579CD, 18};

        do_reset();
        check("rst_read",    32'(read),            32'd0);
        check("rst_write",   32'(write),           32'd0);
        check("rst_busy",    32'(busy),            32'd0);
        check("rst_overrun", 32'(overrun),         32'd0);
        check("rst_wd_l",    32'(writedata_left),  32'd0);
        check("rst_wd_r",    32'(writedata_right), 32'd0);
        check("rst_count",   32'(sample_count),    32'd0);

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].l, vecs[i].r, vecs[i].byp, vecs[i].el, vecs[i].er, vecs[i].lat);
        end

        // Full-scale extremes: averages must land exactly on the rails.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            x = (i < 8) ? 24'h7FFFF8 : 24'h800000;
            if (i < 8) ex = 24'((i + 1) * 32'h000FFFFF);
            else       ex = 24'((15 - i) * 32'h000FFFFF + (i - 7) * 32'h00F00000);
            send(x, x, 1'b0, ex, ex, 18);
        end

        // write_ready stall past STALL_MAX.
        do_reset();
        write_ready = 1'b0;
        @(negedge clk);
        readdata_left  = 24'h000800;
        readdata_right = 24'h000000;
        bypass         = 1'b0;
        read_ready     = 1'b1;
        n = 0;
        while (!read && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_read_pulse", 32'(read), 32'd1);
        read_ready = 1'b0;
        mon_e.l = 24'h000100;
        mon_e.r = 24'h000000;
        sb.push_back(mon_e);
        reads  = 0;
        writes = 0;
        repeat (17 + STALL_MAX) begin
            @(negedge clk);
            if (read)  reads++;
            if (write) writes++;
        end
        check("overrun_before_limit", 32'(overrun), 32'd0);
        @(negedge clk);
        if (read)  reads++;
        if (write) writes++;
        check("overrun_at_limit", 32'(overrun), 32'd1);
        check("stall_reads", reads, 0);
        check("stall_writes", writes, 0);
        write_ready = 1'b1;
        n = 0;
        while (!write && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("stall_write_pulse", 32'(write), 32'd1);
        @(negedge clk);
        exp_cnt++;
        check("stall_sample_count", 32'(sample_count), exp_cnt);
        repeat (5) @(negedge clk);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of ACC_L drops the in-flight sample.
        @(negedge clk);
        readdata_left  = 24'h000800;
        readdata_right = 24'h000800;
        read_ready     = 1'b1;
        n = 0;
        while (!read && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_read_pulse", 32'(read), 32'd1);
        read_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_cnt = 0;
        check("abort_busy",    32'(busy),            32'd0);
        check("abort_wd_l",    32'(writedata_left),  32'd0);
        check("abort_wd_r",    32'(writedata_right), 32'd0);
        check("abort_overrun", 32'(overrun),         32'd0);
        check("abort_count",   32'(sample_count),    32'd0);
        writes = 0;
        repeat (30) begin
            @(negedge clk);
            if (write) writes++;
        end
        check("abort_no_write", writes, 0);
        send(24'h000800, 24'h000800, 1'b0, 24'h000100, 24'h000100, 18);

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
